// File: rtl/mips_mem_pkg.sv
// Shared types and default latencies for the multi-cycle MIPS memory path.
// The control-unit testbench reuses these types.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int DEF_READ_LAT  = 2;
    localparam int DEF_WRITE_LAT = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed storage with a synchronous write port and a registered,
// enable-gated read port whose output register clears on reset.
module mem_word_array #(
  parameter int    DATA_W     = 32,
  parameter int    DEPTH_LOG2 = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // The read register doubles as the held ReadData output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder: latches a MemRead/MemWrite request, inserts wait
// states, then returns a one-cycle MemReady (with MemErr on illegal access).
module mem_wait_responder
    import mips_mem_pkg::*;
#(
    parameter int    ADDR_W     = 32,
    parameter int    DATA_W     = 32,
    parameter int    DEPTH_LOG2 = 8,
    parameter int    READ_LAT   = DEF_READ_LAT,
    parameter int    WRITE_LAT  = DEF_WRITE_LAT,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemBusy,
    output logic              MemErr
);

    localparam int MAX_LAT = max_int(READ_LAT, WRITE_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_CNT0 = (READ_LAT  > 1) ? CNT_W'(READ_LAT  - 2) : '0;
    localparam logic [CNT_W-1:0] WR_CNT0 = (WRITE_LAT > 1) ? CNT_W'(WRITE_LAT - 2) : '0;

    state_t                  state, next_state;
    op_t                     op_q, req_op, cur_op;
    logic [DEPTH_LOG2-1:0]   idx_q, req_idx, cur_idx;
    logic [DATA_W-1:0]       wdata_q, cur_wdata;
    logic                    err_q, req_err, cur_err;
    logic [CNT_W-1:0]        cnt;
    logic                    req, req_wait, commit, arr_we, arr_re;

    // Live request decode, used while IDLE.
    assign req      = MemRead | MemWrite;
    assign req_op   = MemWrite ? OP_WR : OP_RD;
    assign req_idx  = Addr[DEPTH_LOG2+1:2];
    assign req_err  = (Addr[1:0] != 2'b00) | (|Addr[ADDR_W-1:DEPTH_LOG2+2]) | (MemRead & MemWrite);
    assign req_wait = (req_op == OP_WR) ? (WRITE_LAT > 1) : (READ_LAT > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = req_wait ? BUSY : RESP;
            BUSY:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        MemReady = (state == RESP);
        MemBusy  = (state == BUSY);
        MemErr   = (state == RESP) && err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else if (state == IDLE && req) begin
            op_q    <= req_op;
            idx_q   <= req_idx;
            wdata_q <= WriteData;
            err_q   <= req_err;
            cnt     <= (req_op == OP_WR) ? WR_CNT0 : RD_CNT0;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A single-cycle access enters RESP on the sampling edge itself, so the
    // array is fed the live request in IDLE and the latched copy otherwise.
    always_comb begin
        cur_op    = (state == IDLE) ? req_op    : op_q;
        cur_idx   = (state == IDLE) ? req_idx   : idx_q;
        cur_wdata = (state == IDLE) ? WriteData : wdata_q;
        cur_err   = (state == IDLE) ? req_err   : err_q;
        commit    = (next_state == RESP) && (state != RESP) && !rst;
        arr_we    = commit && (cur_op == OP_WR) && !cur_err;
        arr_re    = commit && (cur_op == OP_RD) && !cur_err;
    end

    mem_word_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (ReadData)
    );

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: one instance with READ_LAT=2/WRITE_LAT=1
// and a second with WRITE_LAT=3 for the reset-during-wait scenario.
module tb_mem_wait_responder;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        MemRead, MemWrite, MemRead3, MemWrite3;
    logic [31:0] Addr, WriteData, Addr3, WriteData3;
    logic [31:0] ReadData, ReadData3;
    logic        MemReady, MemBusy, MemErr;
    logic        MemReady3, MemBusy3, MemErr3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wait_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .READ_LAT(2), .WRITE_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .MemReady(MemReady), .MemBusy(MemBusy), .MemErr(MemErr)
    );

    mem_wait_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .READ_LAT(2), .WRITE_LAT(3)
    ) dut3 (
        .clk(clk), .rst(rst3), .MemRead(MemRead3), .MemWrite(MemWrite3),
        .Addr(Addr3), .WriteData(WriteData3), .ReadData(ReadData3),
        .MemReady(MemReady3), .MemBusy(MemBusy3), .MemErr(MemErr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Present a request for one edge; returns at the negedge after the sampling edge.
    task automatic req(input bit s3, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (s3) begin
            MemRead3 = rd; MemWrite3 = wr; Addr3 = a; WriteData3 = d;
        end else begin
            MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
        end
        @(negedge clk);
        if (s3) begin
            MemRead3 = 1'b0; MemWrite3 = 1'b0;
        end else begin
            MemRead = 1'b0; MemWrite = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        MemRead3 = 1'b0; MemWrite3 = 1'b0; Addr3 = '0; WriteData3 = '0;
        tick; tick;
        chk("rst_rdata",  ReadData, 32'h0);
        chk("rst_ready",  MemReady, 1'b0);
        chk("rst_busy",   MemBusy,  1'b0);
        chk("rst_err",    MemErr,   1'b0);
        chk("rst3_rdata", ReadData3, 32'h0);
        rst = 1'b0; rst3 = 1'b0;
        tick;

        // Single-cycle write
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("t1_ready", MemReady, 1'b1);
        chk("t1_err",   MemErr,   1'b0);
        chk("t1_busy",  MemBusy,  1'b0);
        chk("t1_rdata", ReadData, 32'h0);
        tick;
        chk("t1_idle",  MemReady, 1'b0);

        // Two-cycle read
        req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("t2_busy",   MemBusy,  1'b1);
        chk("t2_early",  MemReady, 1'b0);
        tick;
        chk("t2_ready",  MemReady, 1'b1);
        chk("t2_rdata",  ReadData, 32'hDEADBEEF);
        chk("t2_err",    MemErr,   1'b0);
        chk("t2_nobusy", MemBusy,  1'b0);
        tick;
        chk("t2_pulse",  MemReady, 1'b0);
        chk("t2_hold",   ReadData, 32'hDEADBEEF);

        // Misaligned read: full latency, error, data held
        req(0, 1'b1, 1'b0, 32'h13, 32'h0);
        chk("t3_busy",  MemBusy,  1'b1);
        tick;
        chk("t3_ready", MemReady, 1'b1);
        chk("t3_err",   MemErr,   1'b1);
        chk("t3_rdata", ReadData, 32'hDEADBEEF);
        tick;
        chk("t3_errclr", MemErr, 1'b0);

        // Out-of-range write aliases word 0 in the index bits but must not land
        req(0, 1'b0, 1'b1, 32'h0, 32'h11111111);
        chk("t4_wr0_ready", MemReady, 1'b1);
        tick;
        req(0, 1'b0, 1'b1, 32'h400, 32'hBADBAD00);
        chk("t4_oor_ready", MemReady, 1'b1);
        chk("t4_oor_err",   MemErr,   1'b1);
        tick;
        req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        tick;
        chk("t4_rd_ready", MemReady, 1'b1);
        chk("t4_rd_err",   MemErr,   1'b0);
        chk("t4_rd_data",  ReadData, 32'h11111111);
        tick;

        // Both strobes: write latency, error, no write
        req(0, 1'b1, 1'b1, 32'h10, 32'h55555555);
        chk("both_ready", MemReady, 1'b1);
        chk("both_err",   MemErr,   1'b1);
        chk("both_rdata", ReadData, 32'h11111111);
        tick;
        req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        tick;
        chk("both_rdback", ReadData, 32'hDEADBEEF);
        tick;

        // Held MemRead: completions every READ_LAT+1 cycles
        @(negedge clk);
        MemRead = 1'b1; Addr = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("t6_ready_c%0d", i), MemReady, (i <= 8 && i % 3 == 2) ? 1'b1 : 1'b0);
            if (i == 8) MemRead = 1'b0;
        end
        chk("t6_rdata", ReadData, 32'h11111111);

        // WRITE_LAT=3 instance: establish a known word, then abort a write with reset
        req(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        chk("t5_pre_busy1", MemBusy3, 1'b1);
        tick;
        chk("t5_pre_busy2", MemBusy3, 1'b1);
        tick;
        chk("t5_pre_ready", MemReady3, 1'b1);
        tick;
        req(1, 1'b0, 1'b1, 32'h20, 32'h12345678);
        chk("t5_busy", MemBusy3, 1'b1);
        rst3 = 1'b1;
        #1;
        chk("t5_rst_busy",  MemBusy3,  1'b0);
        chk("t5_rst_ready", MemReady3, 1'b0);
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_noready_%0d", i), MemReady3, 1'b0);
        end
        req(1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick;
        chk("t5_rd_ready", MemReady3, 1'b1);
        chk("t5_rd_data",  ReadData3, 32'hCAFEF00D);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
